// File: rtl/eth_sdp_ram.sv
// ---------------------------------------------------------------------------
// eth_sdp_ram
//
// Simple dual-port RAM with one write port (per-byte enables) and one read
// port, a 1- or 2-cycle read pipeline, and a clear sweep that writes
// INIT_VALUE into every entry, one entry per cycle.
//
// Optional feature macro: ETH_SDP_RAM_BYPASS_EN
//   defined   : a read that collides with a same-cycle write to the same
//               address returns the merged word (written lanes new, others old)
//   undefined : the colliding read returns the old contents
//
// Ports:
//   clk       in   clock
//   reset     in   synchronous active-high reset (control state only)
//   wr_en     in   [BYTEENW] per-byte write enables
//   wr_addr   in   [ADDRW]   write address
//   wr_data   in   [DATAW]   write data
//   rd_en     in   read request
//   rd_addr   in   [ADDRW]   read address
//   rd_data   out  [DATAW]   read data, held between results
//   rd_valid  out  one-cycle pulse per accepted read
//   clr_req   in   start a clear sweep
//   clr_busy  out  clear sweep in progress
// ---------------------------------------------------------------------------
module eth_sdp_ram #(
  parameter int                DATAW      = 32,
  parameter int                SIZE       = 64,
  parameter int                BYTEENW    = 4,
  parameter int                OUT_REG    = 0,
  parameter int                ADDRW      = $clog2(SIZE),
  parameter logic [DATAW-1:0]  INIT_VALUE = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BYTEENW-1:0] wr_en,
  input  logic [ADDRW-1:0]   wr_addr,
  input  logic [DATAW-1:0]   wr_data,
  input  logic               rd_en,
  input  logic [ADDRW-1:0]   rd_addr,
  output logic [DATAW-1:0]   rd_data,
  output logic               rd_valid,
  input  logic               clr_req,
  output logic               clr_busy
);

  localparam int               IDXW     = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int               LANEW    = DATAW / BYTEENW;
  localparam logic [ADDRW:0]   SIZE_EXT = (ADDRW+1)'(SIZE);
  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(SIZE - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  logic [DATAW-1:0] mem [SIZE];

  state_t           state;
  logic [IDXW-1:0]  clr_cnt;

  logic             wr_in_range;
  logic             rd_in_range;
  logic             wr_ok;
  logic             rd_acc;
  logic [IDXW-1:0]  wr_idx;
  logic [IDXW-1:0]  rd_idx;
  logic [DATAW-1:0] rd_word;

  logic             s1_valid;
  logic [DATAW-1:0] s1_data;

  // ADDRW may be wider than the array index, so out-of-range addresses are
  // detected on the full address before it is truncated for indexing.
  assign wr_in_range = {1'b0, wr_addr} < SIZE_EXT;
  assign rd_in_range = {1'b0, rd_addr} < SIZE_EXT;
  assign wr_ok       = !clr_busy && wr_in_range && (|wr_en);
  assign rd_acc      = rd_en && !clr_busy;
  assign wr_idx      = IDXW'(wr_addr);
  assign rd_idx      = IDXW'(rd_addr);

`ifdef ETH_SDP_RAM_BYPASS_EN
  // Forward the enabled lanes of a same-cycle write so the read sees the
  // word as it will be after this edge.
  always_comb begin
    rd_word = rd_in_range ? mem[rd_idx] : INIT_VALUE;
    if (rd_in_range && wr_ok && (wr_addr == rd_addr)) begin
      for (int i = 0; i < BYTEENW; i++) begin
        if (wr_en[i]) begin
          rd_word[i*LANEW +: LANEW] = wr_data[i*LANEW +: LANEW];
        end
      end
    end
  end
`else
  // A same-cycle write lands at the edge, so the array still holds the old word.
  assign rd_word = rd_in_range ? mem[rd_idx] : INIT_VALUE;
`endif

  // Clear FSM: one entry per cycle from 0 to SIZE-1; further clr_req pulses
  // are ignored until the sweep is done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      clr_cnt  <= '0;
      clr_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_cnt == LAST_IDX) begin
            state    <= IDLE;
            clr_cnt  <= '0;
            clr_busy <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          clr_cnt  <= '0;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

  // Array write port. Reset never touches contents, but it does suppress the
  // sweep write of the cycle it aborts so that entry keeps its old data.
  always_ff @(posedge clk) begin
    if (clr_busy && !reset) begin
      mem[clr_cnt] <= INIT_VALUE;
    end else if (wr_ok) begin
      for (int i = 0; i < BYTEENW; i++) begin
        if (wr_en[i]) begin
          mem[wr_idx][i*LANEW +: LANEW] <= wr_data[i*LANEW +: LANEW];
        end
      end
    end
  end

  // First read stage; the data register only loads on an accepted read so
  // the output holds its last result in between.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_acc;
      if (rd_acc) begin
        s1_data <= rd_word;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic             s2_valid;
      logic [DATAW-1:0] s2_data;

      // Optional output register adding one cycle of read latency.
      always_ff @(posedge clk) begin
        if (reset) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_data <= s1_data;
          end
        end
      end

      assign rd_valid = s2_valid;
      assign rd_data  = s2_data;
    end else begin : g_no_out_reg
      assign rd_valid = s1_valid;
      assign rd_data  = s1_data;
    end
  endgenerate

endmodule

// File: doc/eth_sdp_ram.md
ETH_SDP_RAM -- requirements
Module: eth_sdp_ram

Interface
REQ-001 Parameter DATAW, default 32: data width in bits; SHALL equal 8*BYTEENW when BYTEENW > 1.
REQ-002 Parameter SIZE, default 64: number of entries, 2..4096.
REQ-003 Parameter BYTEENW, default 4: number of byte-enable lanes; 1 means a single whole-word enable.
REQ-004 Parameter OUT_REG, default 0: 0 gives a read latency of 1 cycle, 1 gives a read latency of 2 cycles.
REQ-005 Parameter ADDRW, default $clog2(SIZE): address width.
REQ-006 Parameter INIT_VALUE, default 0: DATAW-bit word written by the clear sweep.
REQ-007 Clock and reset: one clock; reset is synchronous and active-high; port names are clk and reset.
REQ-008 Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- wr_en  in  BYTEENW  per-byte write enables
- wr_addr  in  ADDRW  write address
- wr_data  in  DATAW  write data
- rd_en  in  1  read request
- rd_addr  in  ADDRW  read address
- rd_data  out  DATAW  read data
- rd_valid  out  1  rd_data holds the result of an accepted read
- clr_req  in  1  start a clear sweep
- clr_busy  out  1  clear sweep in progress

Function
REQ-009 The write and read ports SHALL be independent, so one write and one read can happen in the same cycle.
REQ-010 Write: on a clk edge with wr_en[i]=1 and clr_busy=0, byte lane i of entry wr_addr SHALL take wr_data[8i+7:8i]; lanes with wr_en[i]=0 are unchanged. When BYTEENW=1, wr_en[0] writes the whole word.
REQ-011 Read accept: a read is accepted when rd_en=1 and clr_busy=0; rd_en while clr_busy=1 SHALL be ignored.
REQ-012 Read latency: for an accepted read in cycle N, rd_data SHALL be valid with rd_valid=1 in cycle N+1 (OUT_REG=0) or N+2 (OUT_REG=1).
REQ-013 rd_valid SHALL be high for exactly one cycle per accepted read; back-to-back reads give one result per cycle with full throughput.
REQ-014 rd_data SHALL hold its last value while rd_valid=0.
REQ-015 Addresses >= SIZE: writes SHALL be dropped; reads SHALL return INIT_VALUE with rd_valid asserted.
REQ-016 Clear FSM states: IDLE and CLEAR.
- IDLE to CLEAR on clr_req=1.
- In CLEAR, a counter runs from 0 to SIZE-1 and writes INIT_VALUE to one entry per cycle.
- CLEAR to IDLE after entry SIZE-1 is written.
REQ-017 clr_busy SHALL be 1 in the cycle after clr_req is sampled and for exactly SIZE cycles in total.
REQ-018 clr_req during CLEAR SHALL be ignored, with no restart.
REQ-019 Reads already accepted before clr_busy rises SHALL complete normally.
REQ-020 Writes presented while clr_busy=1 SHALL be discarded.

Reset
REQ-021 When reset=1 at a clk edge, the block SHALL set: FSM to IDLE, clear counter to 0, clr_busy to 0, rd_valid and the whole read pipeline to 0, and rd_data to 0.
REQ-022 Reset SHALL NOT modify memory contents.
REQ-023 Reset during CLEAR SHALL abort the sweep; entries already cleared stay cleared and the rest keep their old contents.
REQ-024 Reads in flight at reset SHALL be dropped with no rd_valid.

Configuration
REQ-025 Macro ETH_SDP_RAM_BYPASS_EN, when defined: a read accepted in the same cycle as a write to the same address SHALL return merged data (enabled lanes from wr_data, other lanes from the old contents).
REQ-026 Without ETH_SDP_RAM_BYPASS_EN, the same collision SHALL return the old contents, and the new data is visible to reads from the next cycle on.

Verification
REQ-027 Scenario, OUT_REG=0: write 0xDEADBEEF to address 5 with wr_en=0xF; read address 5 one cycle later -> next cycle rd_data=0xDEADBEEF, rd_valid=1 for 1 cycle.
REQ-028 Scenario, byte enables: write 0x11223344 to address 3 with wr_en=0xF; then write 0xAABBCCDD with wr_en=0x5; read address 3 -> rd_data=0x11BB33DD.
REQ-029 Scenario, OUT_REG=1: reads of addresses 0,1,2 in consecutive cycles -> rd_valid high on cycles N+2..N+4 with data in order.
REQ-030 Scenario, clear: SIZE=64, INIT_VALUE=0xA5A5A5A5; pulse clr_req -> clr_busy=1 for 64 cycles, a write during that window is discarded, then all 64 addresses read 0xA5A5A5A5.
REQ-031 Scenario, reset at sweep cycle 10 of 64 -> clr_busy=0 next cycle; addresses 0..9 read INIT_VALUE; address 10 and up keep their prior data.
REQ-032 Scenario, collision: same-cycle write of 0x12345678 to address 7 (old 0) and read of address 7 -> rd_data=0x12345678 with the macro defined, 0x00000000 without it.
